alu_op_sequencer: RTL and testbench
===================================

# alu_op_sequencer

Command-issuing front end for the 32-bit combinational ALU: queues operation requests, drives the ALU operand/opcode inputs from registers, captures the result one cycle later and returns it through a valid/ready result port. Adds result chaining, where the previous result is used as operand A, and a divide-by-zero guard. It is the initiator side of the ALU interface and sits between the datapath control logic and the ALU instance.

## Interface
- DEPTH, 4, command FIFO depth in entries; power of two, at least 2.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command can be accepted. Equals FIFO not full and rst low.
- cmd_op  in  2  00 add, 01 sub, 10 mul, 11 div.
- cmd_a, cmd_b  in  32 each  operands.
- cmd_cin  in  1  carry-in; used only when the op is add.
- cmd_chain  in  1  when 1, the effective A is the last result and cmd_a is ignored.
- alu_a, alu_b  out  32 each  registered operands to the ALU.
- alu_cin  out  1  registered carry-in to the ALU.
- alu_op  out  2  registered opcode to the ALU.
- alu_f  in  32  ALU result (combinational from alu_*).
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts the result.
- res_data  out  32  result value.
- res_op  out  2  opcode that produced res_data.
- res_err  out  1  divide by zero.
- busy  out  1  high when the FSM is not in IDLE or the FIFO is not empty.

## Operation
- **Command FIFO**
  - A push occurs when cmd_valid and cmd_ready are both high at a clock edge.
  - Each entry stores {op, a, b, cin, chain}.
  - Read and write pointers wrap modulo DEPTH. The count runs 0..DEPTH.
  - A push and a pop in the same edge are both allowed; the count is unchanged.
  - Full blocks pushes through cmd_ready. Pops only occur when the FIFO is not empty.
- **FSM states: IDLE, EXEC, RESP.**
  - **IDLE:** if the FIFO is not empty, pop the head entry, load the alu_* registers, and go to EXEC.
  - **EXEC:** capture the result into res_data, set res_op and res_err, set res_valid to 1, update last_result, and go to RESP.
  - **RESP:** hold res_valid and res_data stable until res_valid and res_ready are both high at an edge. On that edge, clear res_valid. If the FIFO is not empty, pop and load on the same edge and go to EXEC; otherwise go to IDLE.
- **Operand load**
  - alu_a is last_result if chain=1, else cmd_a.
  - alu_b is cmd_b.
  - alu_op is cmd_op.
  - alu_cin is cin when op=00, else 0.
- **Result capture**
  - When op=11 and alu_b=0, the captured result is res_data=32'hFFFF_FFFF and res_err=1; alu_f is ignored.
  - Otherwise res_data=alu_f and res_err=0.
- **Arithmetic**
  - All results are taken modulo 2^32; no overflow or carry-out is reported.
  - Subtraction is A−B in two's complement. Cin does not apply to subtraction.
- **last_result**
  - Resets to 0.
  - Updated at every EXEC capture, including error results. A chain after an error therefore uses 32'hFFFF_FFFF.
- alu_* outputs hold their last loaded value while in IDLE and RESP.

## Timing
- Reset values, asynchronous:
  - State is IDLE.
  - FIFO is empty.
  - alu_a=0, alu_b=0, alu_cin=0, alu_op=00.
  - res_valid=0, res_data=0, res_op=00, res_err=0.
  - last_result=0.
  - busy=0.
  - cmd_ready=0 while rst is high and 1 on the first cycle after release.
- Latency: a command accepted at edge E into an empty, idle block is popped at E+1; res_valid rises after edge E+2.
- Throughput: with res_ready held high, one result is produced every 2 cycles (EXEC and RESP alternate).
- res_ready low stalls the FSM in RESP. The FIFO keeps accepting commands until full.
- Commands complete strictly in acceptance order.
- A reset asserted mid-operation aborts immediately:
  - The queued commands and any pending result are discarded.
  - The first result after reset is computed from a fresh command, with last_result=0.

## Test plan
- **Single add:** cmd {00, A=5, B=7, cin=1} -> res_valid after 2 cycles, res_data=13, res_err=0, res_op=00.
- **Chain:** cmds {10, A=6, B=7}, then {01, chain=1, B=2} -> res_data=42, then 40.
- **Divide by zero:** {11, A=9, B=0} -> res_data=32'hFFFF_FFFF, res_err=1. A following {00, chain=1, B=1, cin=0} -> res_data=0.
- **Backpressure:** hold res_ready=0 and push DEPTH+2 commands.
  - cmd_ready drops after DEPTH+1 accepts (DEPTH in the FIFO, 1 in flight).
  - res_data stays stable while stalled.
  - After releasing res_ready, all results arrive in order and pointers wrap correctly.
- **Reset mid-operation:** assert rst while in RESP with 2 commands queued.
  - All outputs return to reset values immediately.
  - The next command {00, chain=1, A=0, B=3, cin=0} -> res_data=3.
- **Wrap/overflow:** {00, A=32'hFFFF_FFFF, B=1, cin=1} -> 1; {01, A=0, B=1} -> 32'hFFFF_FFFF; {10, A=32'h10000, B=32'h10000} -> 0.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: queues ALU commands, drives registered operands into the
// combinational ALU, captures the result one cycle later and hands it back over
// a valid/ready port. Supports chaining the previous result as operand A and
// substitutes an all-ones error result for divide by zero.
module alu_op_sequencer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [31:0] cmd_a,
  input  logic [31:0] cmd_b,
  input  logic        cmd_cin,
  input  logic        cmd_chain,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic        alu_cin,
  output logic [1:0]  alu_op,
  input  logic [31:0] alu_f,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic [1:0]  res_op,
  output logic        res_err,
  output logic        busy
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        chain;
  } cmd_t;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  cmd_t          mem_q [DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [PW:0]   cnt_q;

  state_t        state_q;
  logic [31:0]   alu_a_q, alu_b_q, res_data_q, last_q;
  logic [1:0]    alu_op_q, res_op_q;
  logic          alu_cin_q, res_valid_q, res_err_q;

  logic          full, empty, push, pop, div0;
  cmd_t          cmd_in, head;
  logic [31:0]   cap;

  assign full   = (cnt_q == (PW+1)'(DEPTH));
  assign empty  = (cnt_q == '0);
  assign cmd_in = '{op: cmd_op, a: cmd_a, b: cmd_b, cin: cmd_cin, chain: cmd_chain};
  assign head   = mem_q[rptr_q];

  // cmd_ready is gated by rst so nothing is offered while reset is asserted
  assign cmd_ready = !full && !rst;
  assign push      = cmd_valid && cmd_ready;
  // Pop when the FSM is ready to load: from IDLE, or on the result handshake in RESP
  assign pop       = !empty && ((state_q == S_IDLE) ||
                                (state_q == S_RESP && res_valid_q && res_ready));

  // Divide by zero is detected on the registered operands, so alu_f is never trusted for it
  assign div0 = (alu_op_q == 2'b11) && (alu_b_q == '0);
  assign cap  = div0 ? 32'hFFFF_FFFF : alu_f;

  assign busy      = (state_q != S_IDLE) || !empty;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_cin   = alu_cin_q;
  assign alu_op    = alu_op_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_op    = res_op_q;
  assign res_err   = res_err_q;

  // Command storage; contents need no reset since occupancy is tracked by cnt_q
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= cmd_in;
  end

  // FIFO pointers and occupancy; power-of-two depth lets the pointers wrap naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      if (push && !pop)      cnt_q <= cnt_q + 1'b1;
      else if (pop && !push) cnt_q <= cnt_q - 1'b1;
    end
  end

  // Issue/capture/respond sequencer with registered ALU drive and result outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_cin_q   <= 1'b0;
      alu_op_q    <= 2'b00;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_op_q    <= 2'b00;
      res_err_q   <= 1'b0;
      last_q      <= '0;
    end else begin
      // A pop always loads the ALU regs, whether it comes from IDLE or RESP
      if (pop) begin
        alu_a_q   <= head.chain ? last_q : head.a;
        alu_b_q   <= head.b;
        alu_op_q  <= head.op;
        alu_cin_q <= (head.op == 2'b00) ? head.cin : 1'b0;
      end
      case (state_q)
        S_IDLE: begin
          if (pop) state_q <= S_EXEC;
        end
        S_EXEC: begin
          res_data_q  <= cap;
          res_op_q    <= alu_op_q;
          res_err_q   <= div0;
          res_valid_q <= 1'b1;
          last_q      <= cap;
          state_q     <= S_RESP;
        end
        S_RESP: begin
          if (res_valid_q && res_ready) begin
            res_valid_q <= 1'b0;
            state_q     <= pop ? S_EXEC : S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: table of directed single commands, hand-written
// backpressure and reset sequences, then random traffic against a scoreboard.
module tb_alu_op_sequencer;
  localparam int DEPTH = 4;

  logic        clk, rst, cmd_valid, cmd_ready, cmd_cin, cmd_chain;
  logic [1:0]  cmd_op, alu_op, res_op;
  logic [31:0] cmd_a, cmd_b, alu_a, alu_b, alu_f, res_data;
  logic        alu_cin, res_valid, res_ready, res_err, busy;

  alu_op_sequencer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_cin(cmd_cin), .cmd_chain(cmd_chain),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_op(alu_op), .alu_f(alu_f),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_op(res_op), .res_err(res_err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU; divide by zero returns junk that must never reach res_data
  always_comb begin
    case (alu_op)
      2'b00:   alu_f = alu_a + alu_b + {31'b0, alu_cin};
      2'b01:   alu_f = alu_a - alu_b;
      2'b10:   alu_f = alu_a * alu_b;
      default: alu_f = (alu_b == 0) ? 32'h1234_5678 : alu_a / alu_b;
    endcase
  end

  int nvec = 0;
  int nerr = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  // Scoreboard: expected results computed in acceptance order from the command stream
  typedef struct packed {
    logic [31:0] d;
    logic [1:0]  op;
    logic        err;
  } exp_t;

  exp_t        q[$];
  exp_t        e, n;
  logic [31:0] m_last = 0;
  logic [31:0] a_eff;

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      m_last = 0;
    end else begin
      if (res_valid && res_ready) begin
        if (q.size() == 0) chk("sb_unexpected_result", 32'd1, 32'd0);
        else begin
          e = q.pop_front();
          chk("sb_data", res_data, e.d);
          chk("sb_op", {30'b0, res_op}, {30'b0, e.op});
          chk("sb_err", {31'b0, res_err}, {31'b0, e.err});
        end
      end
      if (cmd_valid && cmd_ready) begin
        a_eff = cmd_chain ? m_last : cmd_a;
        n.op  = cmd_op;
        n.err = 1'b0;
        case (cmd_op)
          2'b00: n.d = a_eff + cmd_b + {31'b0, cmd_cin};
          2'b01: n.d = a_eff - cmd_b;
          2'b10: n.d = a_eff * cmd_b;
          default: begin
            if (cmd_b == 0) begin n.d = 32'hFFFF_FFFF; n.err = 1'b1; end
            else n.d = a_eff / cmd_b;
          end
        endcase
        m_last = n.d;
        q.push_back(n);
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic cin, input logic chain);
    int k = 0;
    @(posedge clk); #1;
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_cin = cin; cmd_chain = chain; cmd_valid = 1'b1;
    do begin @(negedge clk); k++; end while (!cmd_ready && k < 50);
    chk("issue_ready", {31'b0, cmd_ready}, 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_res(output int cyc);
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!res_valid && cyc < 40);
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        cin, chain;
    logic [31:0] exp;
    logic        err;
  } vec_t;

  vec_t tbl[12];

  initial begin
    int cyc, acc;
    logic [31:0] held;

    tbl[0]  = '{2'b00, 32'd5, 32'd7, 1'b1, 1'b0, 32'd13, 1'b0};
    tbl[1]  = '{2'b10, 32'd6, 32'd7, 1'b0, 1'b0, 32'd42, 1'b0};
    tbl[2]  = '{2'b01, 32'd999, 32'd2, 1'b0, 1'b1, 32'd40, 1'b0};
    tbl[3]  = '{2'b11, 32'd9, 32'd0, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b1};
    tbl[4]  = '{2'b00, 32'd77, 32'd1, 1'b0, 1'b1, 32'd0, 1'b0};
    tbl[5]  = '{2'b00, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b0, 32'd1, 1'b0};
    tbl[6]  = '{2'b01, 32'd0, 32'd1, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0};
    tbl[7]  = '{2'b10, 32'h10000, 32'h10000, 1'b0, 1'b0, 32'd0, 1'b0};
    tbl[8]  = '{2'b11, 32'd100, 32'd7, 1'b0, 1'b0, 32'd14, 1'b0};
    tbl[9]  = '{2'b01, 32'd10, 32'd3, 1'b1, 1'b0, 32'd7, 1'b0};
    tbl[10] = '{2'b10, 32'd3, 32'd4, 1'b1, 1'b0, 32'd12, 1'b0};
    tbl[11] = '{2'b11, 32'd0, 32'd5, 1'b0, 1'b1, 32'd2, 1'b0};

    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 0; cmd_a = 0; cmd_b = 0;
    cmd_cin = 0; cmd_chain = 0; res_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'd0);
    chk("rst_res_valid", {31'b0, res_valid}, 32'd0);
    chk("rst_res_data", res_data, 32'd0);
    chk("rst_res_err", {31'b0, res_err}, 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rel_cmd_ready", {31'b0, cmd_ready}, 32'd1);

    // Directed single commands, each into an idle block
    for (int i = 0; i < 12; i++) begin
      issue(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].chain);
      wait_res(cyc);
      chk($sformatf("v%0d_latency", i), cyc, 32'd3);
      chk($sformatf("v%0d_data", i), res_data, tbl[i].exp);
      chk($sformatf("v%0d_err", i), {31'b0, res_err}, {31'b0, tbl[i].err});
      chk($sformatf("v%0d_op", i), {30'b0, res_op}, {30'b0, tbl[i].op});
      chk($sformatf("v%0d_alu_cin", i), {31'b0, alu_cin},
          {31'b0, (tbl[i].op == 2'b00) ? tbl[i].cin : 1'b0});
    end

    // Backpressure: stall results and keep offering commands
    @(posedge clk); #1;
    res_ready = 1'b0; acc = 0; cyc = 0;
    cmd_valid = 1'b1; cmd_op = 2'($urandom); cmd_a = $urandom; cmd_b = $urandom_range(1, 50);
    cmd_cin = 1'($urandom); cmd_chain = 1'($urandom);
    while (acc < DEPTH + 1 && cyc < 40) begin
      @(negedge clk); cyc++;
      if (cmd_ready) acc++;
      @(posedge clk); #1;
      cmd_op = 2'($urandom); cmd_a = $urandom; cmd_b = $urandom_range(1, 50);
      cmd_cin = 1'($urandom); cmd_chain = 1'($urandom);
    end
    chk("bp_accepts", acc, DEPTH + 1);
    @(negedge clk);
    chk("bp_ready_low", {31'b0, cmd_ready}, 32'd0);
    chk("bp_res_valid", {31'b0, res_valid}, 32'd1);
    held = res_data;
    repeat (4) @(negedge clk);
    chk("bp_data_stable", res_data, held);
    chk("bp_ready_still_low", {31'b0, cmd_ready}, 32'd0);
    @(posedge clk); #1;
    cmd_valid = 1'b0; res_ready = 1'b1;
    cyc = 0;
    while ((q.size() != 0 || busy) && cyc < 100) begin @(negedge clk); cyc++; end
    chk("bp_drained", {31'b0, (q.size() == 0 && !busy)}, 32'd1);

    // Reset while holding a result with two commands queued
    res_ready = 1'b0;
    issue(2'b10, 32'd3, 32'd5, 1'b0, 1'b0);
    issue(2'b00, 32'd1, 32'd1, 1'b1, 1'b0);
    issue(2'b01, 32'd9, 32'd2, 1'b0, 1'b0);
    wait_res(cyc);
    chk("mr_res_valid_before", {31'b0, res_valid}, 32'd1);
    @(posedge clk); #1 rst = 1'b1;
    #1;
    chk("mr_res_valid", {31'b0, res_valid}, 32'd0);
    chk("mr_res_data", res_data, 32'd0);
    chk("mr_res_op", {30'b0, res_op}, 32'd0);
    chk("mr_alu_a", alu_a, 32'd0);
    chk("mr_alu_b", alu_b, 32'd0);
    chk("mr_alu_op", {30'b0, alu_op}, 32'd0);
    chk("mr_busy", {31'b0, busy}, 32'd0);
    chk("mr_cmd_ready", {31'b0, cmd_ready}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("mr_cmd_ready_rel", {31'b0, cmd_ready}, 32'd1);
    res_ready = 1'b1;
    issue(2'b00, 32'h55, 32'd3, 1'b0, 1'b1);
    wait_res(cyc);
    chk("mr_first_data", res_data, 32'd3);
    chk("mr_first_latency", cyc, 32'd3);

    // Random traffic checked by the scoreboard
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      cmd_valid = 1'($urandom);
      cmd_op    = 2'($urandom);
      cmd_a     = $urandom;
      cmd_b     = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      cmd_cin   = 1'($urandom);
      cmd_chain = 1'($urandom);
      res_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0; res_ready = 1'b1;
    cyc = 0;
    while ((q.size() != 0 || busy) && cyc < 100) begin @(negedge clk); cyc++; end
    chk("rand_drained", {31'b0, (q.size() == 0 && !busy)}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
